// File: rtl/score_controller.sv
// rtl/score_controller.sv - game state sequencer: serial kill-mask scoring, lives, level and high score
module score_controller #(
    parameter int N_ENEMY      = 8,
    parameter int SCORE_W      = 10,
    parameter int PTS_PER_KILL = 1,
    parameter int START_LIVES  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_start,
    input  logic               kill_valid,
    input  logic [N_ENEMY-1:0] kill_mask,
    output logic               kill_ready,
    input  logic               player_hit,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [1:0]         lives,
    output logic [3:0]         level,
    output logic [N_ENEMY-1:0] alive_mask,
    output logic [1:0]         state,
    output logic               level_clear,
    output logic               game_over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        SCAN = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam int                 IDX_W     = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [N_ENEMY-1:0] ALL_ALIVE = '1;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N_ENEMY - 1);

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic [1:0]         lives_q, lives_d;
    logic [3:0]         level_q, level_d;
    logic [N_ENEMY-1:0] alive_q, alive_d;
    logic [N_ENEMY-1:0] pending_q, pending_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               hit_pend_q, hit_pend_d;
    logic               clear_q, clear_d;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_inc;
    logic               hit_now;

    // One extra bit on the sum lets saturation be detected without wrapping.
    assign score_sum = {1'b0, score_q} + (SCORE_W + 1)'(PTS_PER_KILL);
    assign score_inc = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[SCORE_W-1:0];

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        high_d     = high_q;
        lives_d    = lives_q;
        level_d    = level_q;
        alive_d    = alive_q;
        pending_d  = pending_q;
        idx_d      = idx_q;
        hit_pend_d = hit_pend_q;
        clear_d    = 1'b0;
        hit_now    = hit_pend_q | player_hit;

        case (state_q)
            IDLE, OVER: begin
                if (game_start) begin
                    state_d    = PLAY;
                    score_d    = '0;
                    lives_d    = 2'(START_LIVES);
                    level_d    = 4'd1;
                    alive_d    = ALL_ALIVE;
                    hit_pend_d = 1'b0;
                end
            end
            PLAY: begin
                // A fatal hit wins over a simultaneous kill, which is discarded.
                if (player_hit && (lives_q <= 2'd1)) begin
                    lives_d = 2'd0;
                    state_d = OVER;
                    high_d  = (score_q > high_q) ? score_q : high_q;
                end else begin
                    if (player_hit) begin
                        lives_d = lives_q - 2'd1;
                    end
                    if (kill_valid) begin
                        pending_d  = kill_mask & alive_q;
                        alive_d    = alive_q & ~kill_mask;
                        idx_d      = '0;
                        hit_pend_d = 1'b0;
                        state_d    = SCAN;
                    end
                end
            end
            SCAN: begin
                if (pending_q[idx_q]) begin
                    score_d = score_inc;
                end
                hit_pend_d = hit_now;
                if (idx_q == LAST_IDX) begin
                    state_d    = PLAY;
                    hit_pend_d = 1'b0;
                    if (alive_q == '0) begin
                        clear_d = 1'b1;
                        level_d = (level_q == 4'd15) ? level_q : level_q + 4'd1;
                        alive_d = ALL_ALIVE;
                    end
                    // Deferred hits land after the wave refill so a clear still pulses.
                    if (hit_now) begin
                        if (lives_q > 2'd1) begin
                            lives_d = lives_q - 2'd1;
                        end else begin
                            lives_d = 2'd0;
                            state_d = OVER;
                            high_d  = (score_d > high_q) ? score_d : high_q;
                        end
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            score_q    <= '0;
            high_q     <= '0;
            lives_q    <= '0;
            level_q    <= '0;
            alive_q    <= '0;
            pending_q  <= '0;
            idx_q      <= '0;
            hit_pend_q <= 1'b0;
            clear_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            high_q     <= high_d;
            lives_q    <= lives_d;
            level_q    <= level_d;
            alive_q    <= alive_d;
            pending_q  <= pending_d;
            idx_q      <= idx_d;
            hit_pend_q <= hit_pend_d;
            clear_q    <= clear_d;
        end
    end

    assign kill_ready  = (state_q == PLAY);
    assign score       = score_q;
    assign high_score  = high_q;
    assign lives       = lives_q;
    assign level       = level_q;
    assign alive_mask  = alive_q;
    assign state       = state_q;
    assign level_clear = clear_q;
    assign game_over   = (state_q == OVER);

endmodule

// File: tb/tb_score_controller.sv
// tb/tb_score_controller.sv - directed self-checking bench for score_controller
module tb_score_controller;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, game_start, kill_valid, kill_ready, player_hit;
    logic [7:0] kill_mask, alive_mask;
    logic [9:0] score, high_score;
    logic [1:0] lives, state;
    logic [3:0] level;
    logic       level_clear, game_over;

    logic       s_rst, s_game_start, s_kill_valid, s_kill_ready, s_player_hit;
    logic [7:0] s_kill_mask, s_alive_mask;
    logic [3:0] s_score, s_high_score;
    logic [1:0] s_lives, s_state;
    logic [3:0] s_level;
    logic       s_level_clear, s_game_over;

    int asserts = 0;
    int fails   = 0;

    score_controller dut (
        .clk(clk), .rst(rst), .game_start(game_start),
        .kill_valid(kill_valid), .kill_mask(kill_mask), .kill_ready(kill_ready),
        .player_hit(player_hit), .score(score), .high_score(high_score),
        .lives(lives), .level(level), .alive_mask(alive_mask), .state(state),
        .level_clear(level_clear), .game_over(game_over)
    );

    score_controller #(.SCORE_W(4)) dut_sat (
        .clk(clk), .rst(s_rst), .game_start(s_game_start),
        .kill_valid(s_kill_valid), .kill_mask(s_kill_mask), .kill_ready(s_kill_ready),
        .player_hit(s_player_hit), .score(s_score), .high_score(s_high_score),
        .lives(s_lives), .level(s_level), .alive_mask(s_alive_mask), .state(s_state),
        .level_clear(s_level_clear), .game_over(s_game_over)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic s_kill(input logic [7:0] m);
        s_kill_valid = 1'b1;
        s_kill_mask  = m;
        tick();
        s_kill_valid = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        logic [7:0] mask;
        int         exp_score;

        rst = 1'b1; game_start = 1'b0; kill_valid = 1'b0; kill_mask = '0; player_hit = 1'b0;
        s_rst = 1'b1; s_game_start = 1'b0; s_kill_valid = 1'b0; s_kill_mask = '0; s_player_hit = 1'b0;
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_score", score, 0);
        chk("rst_high", high_score, 0);
        chk("rst_lives", lives, 0);
        chk("rst_level", level, 0);
        chk("rst_alive", alive_mask, 0);
        chk("rst_ready", kill_ready, 0);
        chk("rst_clear", level_clear, 0);
        rst = 1'b0;

        game_start = 1'b1; tick(); game_start = 1'b0;
        chk("start_state", state, 1);
        chk("start_score", score, 0);
        chk("start_lives", lives, 3);
        chk("start_level", level, 1);
        chk("start_alive", alive_mask, 8'hFF);
        chk("start_ready", kill_ready, 1);

        mask = 8'b1010_0101;
        kill_valid = 1'b1; kill_mask = mask; tick(); kill_valid = 1'b0;
        chk("a5_state", state, 2);
        chk("a5_ready", kill_ready, 0);
        chk("a5_alive", alive_mask, 8'h5A);
        exp_score = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_score += int'(mask[i]);
            chk("a5_score_step", score, exp_score);
            chk("a5_state_step", state, (i < 7) ? 2 : 1);
            if (i < 7) chk("a5_ready_step", kill_ready, 0);
        end
        chk("a5_final", score, 4);

        kill_valid = 1'b1; kill_mask = 8'hFF; tick(); kill_valid = 1'b0;
        chk("ff_alive_empty", alive_mask, 0);
        repeat (8) tick();
        chk("ff_score", score, 8);
        chk("ff_state", state, 1);
        chk("ff_clear", level_clear, 1);
        chk("ff_level", level, 2);
        chk("ff_refill", alive_mask, 8'hFF);
        tick();
        chk("ff_clear_once", level_clear, 0);

        kill_valid = 1'b1; kill_mask = 8'h01; tick();
        chk("hold_scan", state, 2);
        repeat (7) tick();
        chk("hold_still_scan", state, 2);
        tick();
        chk("hold_exit", state, 1);
        chk("hold_score1", score, 9);
        tick(); kill_valid = 1'b0;
        chk("hold_reaccept", state, 2);
        repeat (7) tick();
        chk("zero_scan_len", state, 2);
        tick();
        chk("zero_scan_exit", state, 1);
        chk("dead_kill_score", score, 9);
        chk("dead_kill_alive", alive_mask, 8'hFE);

        player_hit = 1'b1; tick(); player_hit = 1'b0;
        chk("hit_play_lives", lives, 2);
        chk("hit_play_state", state, 1);
        game_start = 1'b1; tick(); game_start = 1'b0;
        chk("start_in_play_score", score, 9);
        chk("start_in_play_level", level, 2);

        kill_valid = 1'b1; kill_mask = 8'h02; tick(); kill_valid = 1'b0;
        tick();
        player_hit = 1'b1; tick(); player_hit = 1'b0;
        tick();
        player_hit = 1'b1; tick(); player_hit = 1'b0;
        chk("scan_hit_deferred", lives, 2);
        repeat (3) tick();
        chk("scan_hit_last", lives, 2);
        chk("scan_hit_state", state, 2);
        tick();
        chk("scan_hit_applied", lives, 1);
        chk("scan_hit_score", score, 10);
        chk("scan_hit_exit", state, 1);

        kill_valid = 1'b1; kill_mask = 8'h04; player_hit = 1'b1; tick();
        kill_valid = 1'b0; player_hit = 1'b0;
        chk("fatal_state", state, 3);
        chk("fatal_over", game_over, 1);
        chk("fatal_score", score, 10);
        chk("fatal_alive", alive_mask, 8'hFC);
        chk("fatal_lives", lives, 0);
        chk("fatal_high", high_score, 10);
        chk("fatal_ready", kill_ready, 0);

        player_hit = 1'b1; tick(); player_hit = 1'b0;
        chk("over_hit_state", state, 3);
        chk("over_hit_lives", lives, 0);

        game_start = 1'b1; tick(); game_start = 1'b0;
        chk("restart_state", state, 1);
        chk("restart_score", score, 0);
        chk("restart_lives", lives, 3);
        chk("restart_level", level, 1);
        chk("restart_high", high_score, 10);
        for (int i = 0; i < 3; i++) begin
            player_hit = 1'b1; tick(); player_hit = 1'b0;
            chk("triple_hit_lives", lives, 2 - i);
        end
        chk("triple_hit_state", state, 3);
        chk("triple_hit_over", game_over, 1);
        chk("triple_hit_high", high_score, 10);

        game_start = 1'b1; tick(); game_start = 1'b0;
        player_hit = 1'b1; tick(); tick(); player_hit = 1'b0;
        chk("two_hits_lives", lives, 1);
        kill_valid = 1'b1; kill_mask = 8'hFF; tick(); kill_valid = 1'b0;
        tick();
        player_hit = 1'b1; tick(); player_hit = 1'b0;
        repeat (6) tick();
        chk("clear_over_pulse", level_clear, 1);
        chk("clear_over_level", level, 2);
        chk("clear_over_state", state, 3);
        chk("clear_over_lives", lives, 0);
        chk("clear_over_score", score, 8);
        chk("clear_over_high", high_score, 10);
        chk("clear_over_alive", alive_mask, 8'hFF);

        game_start = 1'b1; tick(); game_start = 1'b0;
        kill_valid = 1'b1; kill_mask = 8'h0F; tick(); kill_valid = 1'b0;
        repeat (3) tick();
        chk("pre_abort_state", state, 2);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_state", state, 0);
        chk("abort_score", score, 0);
        chk("abort_high", high_score, 0);
        chk("abort_lives", lives, 0);
        chk("abort_level", level, 0);
        chk("abort_alive", alive_mask, 0);
        chk("abort_clear", level_clear, 0);
        chk("abort_over", game_over, 0);

        s_rst = 1'b0;
        s_game_start = 1'b1; tick(); s_game_start = 1'b0;
        s_kill(8'hFF);
        chk("sat_wave1", s_score, 8);
        chk("sat_level", s_level, 2);
        s_kill(8'h3F);
        chk("sat_near_max", s_score, 14);
        s_kill(8'hC0);
        chk("sat_clamp", s_score, 15);
        chk("sat_clear", s_level_clear, 1);
        s_kill(8'h07);
        chk("sat_hold", s_score, 15);
        chk("sat_alive", s_alive_mask, 8'hF8);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
